// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: default widths, state
// encoding, owner codes and the starvation/timeout defaults.
package dmem_arbiter_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int DMEM_WIDTH_DEF = 10;

  localparam int ARB_MAX_WAIT = 4;
  localparam int ARB_TIMEOUT  = 255;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic ARB_OWNER_EXE = 1'b0;
  localparam logic ARB_OWNER_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the execute load/store path and the
// debug/loader port; fixed execute priority with starvation and timeout guards.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DMEM_WIDTH = DMEM_WIDTH_DEF,
  parameter int XLEN       = XLEN_DEF,
  parameter int MAX_WAIT   = ARB_MAX_WAIT,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exe_req,
  input  logic                  exe_we,
  input  logic [DMEM_WIDTH-1:0] exe_addr,
  input  logic [XLEN-1:0]       exe_wdata,
  input  logic [3:0]            exe_be,
  output logic                  exe_done,
  output logic                  exe_err,
  output logic [XLEN-1:0]       exe_rdata,
  output logic                  stall_exe,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DMEM_WIDTH-1:0] dbg_addr,
  input  logic [XLEN-1:0]       dbg_wdata,
  input  logic [3:0]            dbg_be,
  output logic                  dbg_done,
  output logic                  dbg_err,
  output logic [XLEN-1:0]       dbg_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DMEM_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);

  arb_state_t    state_reg;
  logic          owner_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [SW-1:0] starve_cnt_reg;

  logic          starved;
  logic          exe_win;
  logic          dbg_win;
  logic [TW-1:0] tmo_next;
  logic          tmo_hit;

  always_comb begin
    starved  = (starve_cnt_reg == SW'(MAX_WAIT));
    exe_win  = exe_req & ~(dbg_req & starved);
    dbg_win  = dbg_req & ~exe_win;
    tmo_next = tmo_cnt_reg + 1'b1;
    // tmo_next counts the current BUSY cycle, so the port is held for exactly TIMEOUT cycles
    tmo_hit  = (tmo_next == TW'(TIMEOUT));
  end

  assign stall_exe = exe_req & ~exe_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= ARB_OWNER_EXE;
      tmo_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      exe_done       <= 1'b0;
      exe_err        <= 1'b0;
      exe_rdata      <= '0;
      dbg_done       <= 1'b0;
      dbg_err        <= 1'b0;
      dbg_rdata      <= '0;
    end else begin
      exe_done <= 1'b0;
      dbg_done <= 1'b0;
      exe_err  <= 1'b0;
      dbg_err  <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (exe_win || dbg_win) begin
            owner_reg   <= dbg_win ? ARB_OWNER_DBG : ARB_OWNER_EXE;
            mem_req     <= 1'b1;
            mem_we      <= dbg_win ? dbg_we    : exe_we;
            mem_addr    <= dbg_win ? dbg_addr  : exe_addr;
            mem_wdata   <= dbg_win ? dbg_wdata : exe_wdata;
            mem_be      <= dbg_win ? dbg_be    : exe_be;
            tmo_cnt_reg <= '0;
            state_reg   <= ARB_BUSY;
            if (dbg_win)
              starve_cnt_reg <= '0;
            else if (dbg_req && !starved)
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end
        end
        ARB_BUSY: begin
          tmo_cnt_reg <= tmo_next;
          if (mem_ack || tmo_hit) begin
            mem_req   <= 1'b0;
            state_reg <= ARB_DONE;
            if (owner_reg == ARB_OWNER_DBG) begin
              dbg_done  <= 1'b1;
              dbg_err   <= ~mem_ack;
              dbg_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              exe_done  <= 1'b1;
              exe_err   <= ~mem_ack;
              exe_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        ARB_DONE: state_reg <= ARB_IDLE;
        default:  state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the execute-stage load/store path and a debug/loader port.
- Registers the winning request, drives the memory port until the memory acknowledges, then returns registered read data with a one-cycle done pulse.
- Generates the execute-stage stall while an execute access is outstanding.
- Fixed priority to execute; a starvation counter guarantees debug service; a timeout counter aborts hung accesses.

Parameters:
- DMEM_WIDTH, `DMEM_WIDTH, word-address width of the data memory.
- XLEN, `XLEN (32), data width.
- MAX_WAIT, 4, number of consecutive execute wins tolerated while dbg_req is pending.
- TIMEOUT, 255, maximum BUSY cycles without mem_ack before the access is aborted.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- exe_req  in  1  execute access request; held high with stable fields until exe_done
- exe_we  in  1  1 = store, 0 = load
- exe_addr  in  DMEM_WIDTH  word address
- exe_wdata  in  XLEN  store data
- exe_be  in  4  byte enables
- exe_done  out  1  one-cycle completion pulse
- exe_err  out  1  valid with exe_done; 1 = access timed out
- exe_rdata  out  XLEN  load data, valid with exe_done
- stall_exe  out  1  pipeline stall, equal to exe_req & ~exe_done
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be  in  1/1/DMEM_WIDTH/XLEN/4  debug request, same protocol as exe_*
- dbg_done, dbg_err  out  1  same meaning as exe_done / exe_err
- dbg_rdata  out  XLEN  same meaning as exe_rdata
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  DMEM_WIDTH  memory word address
- mem_wdata  out  XLEN  memory write data
- mem_be  out  4  memory byte enables
- mem_ack  in  1  memory completion; rdata valid the same cycle
- mem_rdata  in  XLEN  memory read data

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All registered outputs = 0: mem_*, *_done, *_err, *_rdata.
  - starve_cnt = 0, tmo_cnt = 0.
  - A reset mid-access drops mem_req immediately; no done pulse is issued.
- States are IDLE, BUSY and DONE; owner is a 1-bit register (0 = exe, 1 = dbg).
- IDLE:
  - If exactly one request is high, that requester wins.
  - If both are high, exe wins unless starve_cnt == MAX_WAIT, in which case dbg wins.
  - On a win, latch we/addr/wdata/be and the owner, set mem_req = 1 at the next edge, clear tmo_cnt, and go to BUSY.
  - No request: stay in IDLE with mem_req = 0.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) when exe wins while dbg_req is high.
  - Clears when dbg wins.
- BUSY:
  - mem_* are driven from the latched registers and stay stable.
  - tmo_cnt increments each cycle.
  - On mem_ack: capture mem_rdata into the owner's rdata register, drive err = 0, drop mem_req, go to DONE.
  - If tmo_cnt == TIMEOUT without mem_ack: drop mem_req, rdata = 0, err = 1, go to DONE.
  - If mem_ack and timeout occur in the same cycle, mem_ack wins (err = 0).
- DONE (one cycle):
  - The owner's done pulse is high; the other port's done stays 0.
  - No arbitration happens in this cycle, so the still-high request of the completed requester is not re-accepted.
  - Next state is IDLE.
- Latency:
  - Request in IDLE at cycle 0 → mem_req high at cycles 1..N, where N is the mem_ack cycle.
  - done at cycle N+1; earliest next acceptance at N+2.
  - With zero-wait memory (ack in the first BUSY cycle), a load completes 2 cycles after the request.
- Held rdata: rdata registers hold their value until the next completion for that port.
- Requester fields: request fields that change after acceptance are ignored.
- stall_exe: combinational, high from the exe_req cycle through the cycle before exe_done, including while debug owns the port.
- tmo_cnt width: $clog2(TIMEOUT+1).
- starve_cnt width: $clog2(MAX_WAIT+1).

Decomposition:
- Shared constants package/header: state encoding (ARB_IDLE, ARB_BUSY, ARB_DONE), ARB_OWNER_EXE/ARB_OWNER_DBG, ARB_STATE_WIDTH, and the MAX_WAIT/TIMEOUT defaults.
- Place these alongside the existing XLEN/DMEM_WIDTH definitions in constants.vh.
- Single module; no sub-module needed. The request mux and latch are small enough to stay inline.

Test Plan:
1. Exe load, addr 0x10, mem_ack in the first BUSY cycle, mem_rdata 0xDEADBEEF → mem_req high cycle 1 only, exe_done and exe_rdata = 0xDEADBEEF at cycle 2, stall_exe high cycles 0–1, low at 2.
2. Exe store, addr 0x3, wdata 0x12345678, be 4'b0011, mem_ack delayed 3 cycles → mem_* stable over 3 cycles, exe_done 1 cycle after ack, exe_err = 0.
3. Both requesting continuously, zero-wait memory → grant order exe,exe,exe,exe,dbg (MAX_WAIT = 4); starve_cnt returns to 0 after the dbg grant.
4. Dbg read, mem_ack never arrives, TIMEOUT = 255 → mem_req drops after 255 BUSY cycles, dbg_done = 1 with dbg_err = 1 and dbg_rdata = 0; stall_exe follows exe_req throughout.
5. rst pulsed low during BUSY → mem_req and all outputs go to 0 asynchronously, no done pulse; after release, a pending exe_req is accepted normally.
6. Exe_req held high through DONE → no second mem_req is issued in the DONE cycle; a new access starts only when the request is re-presented in IDLE.
